// File: rtl/zrb_bt_at_config_pkg.sv
// Shared encodings for the HC-06 AT configuration sequencer.
// Latency: n/a (constants and helper only).
// Backpressure: n/a.
package zrb_bt_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FLUSH,
      ST_SEND,
      ST_WAIT_O,
      ST_WAIT_K,
      ST_DRAIN,
      ST_RETRY,
      ST_SWITCH,
      ST_FAIL
   } state_t;

   localparam logic [7:0] CH_A    = 8'h41;
   localparam logic [7:0] CH_T    = 8'h54;
   localparam logic [7:0] CH_PLUS = 8'h2B;
   localparam logic [7:0] CH_B    = 8'h42;
   localparam logic [7:0] CH_U    = 8'h55;
   localparam logic [7:0] CH_D    = 8'h44;
   localparam logic [7:0] CH_O    = 8'h4F;
   localparam logic [7:0] CH_K    = 8'h4B;

   // "AT" probe and "AT+BAUD<code>" command lengths in bytes.
   localparam logic [3:0] CMD0_LEN = 4'd2;
   localparam logic [3:0] CMD1_LEN = 4'd8;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/zrb_bt_at_config_if.sv
// FIFO-side bus of the AT sequencer: RX FIFO head/pop and TX FIFO push.
// Latency: combinational wiring only.
// Backpressure: tx_full holds off tx_wr; rx_rd only pops a valid head.
interface zrb_bt_at_config_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_rd;
   logic       tx_full;
   logic       tx_wr;
   logic [7:0] tx_data;

   modport master (
      input  rx_data, rx_valid, tx_full,
      output rx_rd, tx_wr, tx_data
   );

   modport slave (
      output rx_data, rx_valid, tx_full,
      input  rx_rd, tx_wr, tx_data
   );
endinterface

// File: rtl/zrb_bt_at_config_tick_timer.sv
// Baud-tick counter with clear, saturation and terminal-count compare.
// Latency: expired reflects the registered count (one cycle after the tick).
// Backpressure: none; counts whenever tick is high and not saturated.
module zrb_tick_timer #(
   parameter int W = 14
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         tick,
   input  logic [W-1:0] limit,
   output logic         expired
);

   logic [W-1:0] count;

   // Count baud ticks from the last clear, sticking at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (tick && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

   assign expired = (count >= limit);

endmodule

// File: rtl/zrb_bt_at_config.sv
// HC-06 configuration sequencer: probes with "AT", sends "AT+BAUD<code>", switches speed_select.
// Latency: first tx_wr two cycles after start with an empty RX FIFO; one byte per cycle max.
// Backpressure: tx_full stalls sending with tx_wr low; RX bytes popped only while rx_valid.
module zrb_bt_at_config
   import zrb_bt_pkg::*;
#(
   parameter logic [7:0]  BAUD_CODE     = 8'h38,
   parameter int unsigned TIMEOUT_TICKS = 9600,
   parameter int unsigned QUIET_TICKS   = 96,
   parameter int unsigned RETRIES       = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   baud_tick,
   input  logic                   start,
   zrb_bt_at_config_if.master     bus,
   output logic                   speed_select,
   output logic                   busy,
   output logic                   done,
   output logic                   error
);

   localparam int TW = $clog2(max_u(TIMEOUT_TICKS, QUIET_TICKS) + 1);

   state_t        state_q, state_d;
   logic          cmd_q, cmd_d;
   logic [2:0]    idx_q, idx_d;
   logic [2:0]    try_q, try_d;
   logic          speed_q, speed_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic          tmr_clr, tmr_exp;
   logic [TW-1:0] tmr_limit;
   logic          rx_rd_c, tx_wr_c;
   logic [7:0]    rom_byte;
   logic [2:0]    last_idx;

   // Command ROM addressed by {cmd, idx}.
   always_comb begin
      rom_byte = 8'h00;
      case ({cmd_q, idx_q})
         4'b0_000: rom_byte = CH_A;
         4'b0_001: rom_byte = CH_T;
         4'b1_000: rom_byte = CH_A;
         4'b1_001: rom_byte = CH_T;
         4'b1_010: rom_byte = CH_PLUS;
         4'b1_011: rom_byte = CH_B;
         4'b1_100: rom_byte = CH_A;
         4'b1_101: rom_byte = CH_U;
         4'b1_110: rom_byte = CH_D;
         4'b1_111: rom_byte = BAUD_CODE;
         default:  rom_byte = 8'h00;
      endcase
   end

   assign last_idx  = cmd_q ? 3'(CMD1_LEN - 4'd1) : 3'(CMD0_LEN - 4'd1);
   // One timer serves both the reply timeout and the end-of-reply quiet gap.
   assign tmr_limit = (state_q == ST_DRAIN) ? TW'(QUIET_TICKS) : TW'(TIMEOUT_TICKS);

   zrb_tick_timer #(.W(TW)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (tmr_clr),
      .tick    (baud_tick),
      .limit   (tmr_limit),
      .expired (tmr_exp)
   );

   // Next-state, counters and FIFO strobes.
   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      idx_d   = idx_q;
      try_d   = try_q;
      speed_d = speed_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      error_d = error_q;
      tmr_clr = 1'b0;
      rx_rd_c = 1'b0;
      tx_wr_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               error_d = 1'b0;
               busy_d  = 1'b1;
               cmd_d   = 1'b0;
               try_d   = 3'd1;
               speed_d = 1'b0;
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            rx_rd_c = bus.rx_valid;
            if (!bus.rx_valid) begin
               idx_d   = 3'd0;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (!bus.tx_full) begin
               tx_wr_c = 1'b1;
               if (idx_q == last_idx) begin
                  tmr_clr = 1'b1;
                  state_d = ST_WAIT_O;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         ST_WAIT_O: begin
            if (tmr_exp) begin
               state_d = ST_RETRY;
            end else if (bus.rx_valid) begin
               rx_rd_c = 1'b1;
               if (bus.rx_data == CH_O) state_d = ST_WAIT_K;
            end
         end
         ST_WAIT_K: begin
            if (tmr_exp) begin
               state_d = ST_RETRY;
            end else if (bus.rx_valid) begin
               rx_rd_c = 1'b1;
               if (bus.rx_data == CH_K) begin
                  tmr_clr = 1'b1;
                  state_d = ST_DRAIN;
               end else if (bus.rx_data != CH_O) begin
                  state_d = ST_WAIT_O;
               end
            end
         end
         ST_DRAIN: begin
            if (bus.rx_valid) begin
               rx_rd_c = 1'b1;
               tmr_clr = 1'b1;
            end else if (tmr_exp) begin
               if (!cmd_q) begin
                  cmd_d   = 1'b1;
                  try_d   = 3'd1;
                  state_d = ST_FLUSH;
               end else begin
                  state_d = ST_SWITCH;
               end
            end
         end
         ST_RETRY: begin
            if (try_q == 3'(RETRIES)) begin
               state_d = ST_FAIL;
            end else begin
               try_d   = try_q + 3'd1;
               state_d = ST_FLUSH;
            end
         end
         ST_SWITCH: begin
            speed_d = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         ST_FAIL: begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and status registers; reset aborts any sequence in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cmd_q   <= 1'b0;
         idx_q   <= 3'd0;
         try_q   <= 3'd0;
         speed_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         idx_q   <= idx_d;
         try_q   <= try_d;
         speed_q <= speed_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   assign bus.rx_rd    = rx_rd_c;
   assign bus.tx_wr    = tx_wr_c;
   assign bus.tx_data  = tx_wr_c ? rom_byte : 8'h00;
   assign speed_select = speed_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = error_q;

endmodule
